// File: rtl/fir_interp_pkg.sv
// Shared constants, FSM encodings and output saturation for the 4x polyphase interpolator.
package fir_interp_pkg;

    localparam int unsigned DefTaps   = 16;
    localparam int unsigned DefPhases = 4;
    localparam int unsigned DefDw     = 24;
    localparam int unsigned DefCw     = 16;
    localparam int unsigned DefAw     = 48;

    // Q1.15 coefficients: drop 15 fractional bits after accumulation.
    localparam int unsigned QShift = 15;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMac  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    // Arithmetic shift by QShift, then clamp to a dw-bit signed range (accumulators up to 64 bits).
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int unsigned dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> QShift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fir_interp_sched_if.sv
// Sample, output and coefficient-port bundle for fir_interp_sched.
interface fir_interp_sched_if #(
    parameter int unsigned DW     = 24,
    parameter int unsigned CW     = 16,
    parameter int unsigned ADDR_W = 6
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_sample;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_sample;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [CW-1:0]     coef_wdata;
    logic              coef_err;
    logic              busy;

    modport master (
        output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, out_sample, coef_err, busy
    );

    modport slave (
        input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, out_sample, coef_err, busy
    );

endinterface

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear and accumulate-enable.
module fir_mac_unit #(
    parameter int unsigned DW = 24,
    parameter int unsigned CW = 16,
    parameter int unsigned AW = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_d;
    logic signed [AW-1:0]    acc_q;

    // Sign-extended operands make the modular product exact in DW+CW bits.
    assign prod = {{CW{a_i[DW-1]}}, a_i} * {{DW{b_i[CW-1]}}, b_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_interp_sched.sv
// Polyphase interpolator sequencer: history buffer, coefficient memory and a single time-shared
// MAC producing PHASES outputs per accepted input sample.
module fir_interp_sched
    import fir_interp_pkg::*;
#(
    parameter int unsigned TAPS   = DefTaps,
    parameter int unsigned PHASES = DefPhases,
    parameter int unsigned DW     = DefDw,
    parameter int unsigned CW     = DefCw,
    parameter int unsigned AW     = DefAw
) (
    input logic               clk,
    input logic               rst_n,
    fir_interp_sched_if.slave bus
);

    localparam int unsigned TapW   = $clog2(TAPS);
    localparam int unsigned PhW    = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned AddrW  = $clog2(PHASES * TAPS);
    localparam int unsigned NCoefs = PHASES * TAPS;

    logic [1:0]           state_d, state_q;
    logic [TapW-1:0]      wr_ptr_d, wr_ptr_q;
    logic [TapW-1:0]      tap_d, tap_q;
    logic [PhW-1:0]       phase_d, phase_q;
    logic                 out_valid_d, out_valid_q;
    logic [DW-1:0]        out_sample_d, out_sample_q;
    logic                 coef_err_d, coef_err_q;
    logic signed [DW-1:0] hist_d [TAPS];
    logic signed [DW-1:0] hist_q [TAPS];
    logic signed [CW-1:0] coef_d [NCoefs];
    logic signed [CW-1:0] coef_q [NCoefs];

    logic                 mac_clr;
    logic                 mac_en;
    logic signed [AW-1:0] acc;
    logic [TapW-1:0]      rd_idx;
    logic [AddrW-1:0]     coef_idx;
    logic signed [63:0]   sat_full;

    // Tap 0 is the newest sample, which sits one slot behind the write pointer.
    assign rd_idx   = wr_ptr_q - TapW'(1) - tap_q;
    assign coef_idx = AddrW'({phase_q, tap_q});
    assign sat_full = sat_shift({{(64-AW){acc[AW-1]}}, acc}, DW);

    fir_mac_unit #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (hist_q[rd_idx]),
        .b_i   (coef_q[coef_idx]),
        .acc_o (acc)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tap_d        = tap_q;
        phase_d      = phase_q;
        out_valid_d  = out_valid_q;
        out_sample_d = out_sample_q;
        hist_d       = hist_q;
        coef_d       = coef_q;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        coef_err_d   = bus.coef_we && (state_q != StIdle);

        if (bus.coef_we && (state_q == StIdle)) begin
            coef_d[bus.coef_addr] = bus.coef_wdata;
        end

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    hist_d[wr_ptr_q] = bus.in_sample;
                    wr_ptr_d         = wr_ptr_q + TapW'(1);
                    phase_d          = '0;
                    tap_d            = '0;
                    mac_clr          = 1'b1;
                    state_d          = StMac;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                tap_d  = tap_q + TapW'(1);
                if (tap_q == TapW'(TAPS - 1)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                // First OUT cycle registers the result; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_sample_d = sat_full[DW-1:0];
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (phase_q == PhW'(PHASES - 1)) begin
                        state_d = StIdle;
                    end else begin
                        phase_d = phase_q + PhW'(1);
                        tap_d   = '0;
                        mac_clr = 1'b1;
                        state_d = StMac;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            tap_q        <= '0;
            phase_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            coef_err_q   <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                hist_q[i] <= '0;
            end
            for (int i = 0; i < int'(NCoefs); i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            tap_q        <= tap_d;
            phase_q      <= phase_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            coef_err_q   <= coef_err_d;
            hist_q       <= hist_d;
            coef_q       <= coef_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.coef_err   = coef_err_q;

endmodule

// File: tb/tb_fir_interp_sched.sv
// Directed self-checking bench for fir_interp_sched (TAPS=16, PHASES=4, DW=24, CW=16).
module tb_fir_interp_sched;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fir_interp_sched_if #(.DW(24), .CW(16), .ADDR_W(6)) bus ();

    fir_interp_sched #(
        .TAPS   (16),
        .PHASES (4),
        .DW     (24),
        .CW     (16),
        .AW     (48)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [15:0] data);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 6'(addr);
        bus.coef_wdata = data;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
    endtask

    task automatic send(input logic [23:0] s);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid (counting edges), captures out_sample, then lets one edge complete it.
    task automatic get_out(output logic [23:0] v, output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) begin
            tests++;
            fails++;
            $display("FAIL out_timeout out_valid=%b required=1", bus.out_valid);
        end
        v = bus.out_sample;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests += 5;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.out_sample !== 24'h000000) begin
            fails++; $display("FAIL reset_out_sample got=%h exp=000000", bus.out_sample);
        end
        if (bus.coef_err !== 1'b0) begin
            fails++; $display("FAIL reset_coef_err got=%b exp=0", bus.coef_err);
        end
        if (bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        do_reset();
    endtask

    task automatic test_unity();
        logic [23:0] v;
        int          c;
        do_reset();
        for (int p = 0; p < 4; p++) write_coef(p * 16, 16'h4000);
        send(24'h100000);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++; $display("FAIL unity_busy got=%b exp=1", bus.busy);
        end
        for (int p = 0; p < 4; p++) begin
            get_out(v, c);
            tests += 2;
            if (v !== 24'h080000) begin
                fails++; $display("FAIL unity_value phase=%0d got=%h exp=080000", p, v);
            end
            if (c !== 17) begin
                fails++; $display("FAIL unity_latency phase=%0d got=%0d exp=17", p, c);
            end
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL unity_in_ready_after got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_impulse();
        logic [23:0] v;
        logic [23:0] exp_v;
        logic [63:0] full;
        int          c;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < 16; t++) write_coef(p * 16 + t, 16'((p + 1) * 256));
        end
        for (int n = 0; n < 17; n++) begin
            send((n == 0) ? 24'h7FFFFF : 24'h000000);
            for (int p = 0; p < 4; p++) begin
                get_out(v, c);
                full  = 64'((longint'(8388607) * longint'(p + 1) * 256) >>> 15);
                exp_v = (n < 16) ? full[23:0] : 24'h000000;
                tests++;
                if (v !== exp_v) begin
                    fails++;
                    $display("FAIL impulse n=%0d phase=%0d got=%h exp=%h", n, p, v, exp_v);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] v;
        int          c;
        logic [23:0] pat [2];
        pat[0] = 24'h7FFFFF;
        pat[1] = 24'h800000;
        do_reset();
        for (int a = 0; a < 64; a++) write_coef(a, 16'h7FFF);
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 16; n++) begin
                send(pat[r]);
                for (int p = 0; p < 4; p++) begin
                    get_out(v, c);
                    if (n == 15) begin
                        tests++;
                        if (v !== pat[r]) begin
                            fails++;
                            $display("FAIL saturation run=%0d phase=%0d got=%h exp=%h",
                                     r, p, v, pat[r]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] v;
        logic [23:0] held;
        int          c;
        do_reset();
        for (int p = 0; p < 4; p++) write_coef(p * 16, 16'h4000);
        send(24'h200000);
        for (int p = 0; p < 2; p++) begin
            get_out(v, c);
            tests++;
            if (v !== 24'h100000) begin
                fails++; $display("FAIL bp_early phase=%0d got=%h exp=100000", p, v);
            end
        end
        bus.out_ready = 1'b0;
        c = 0;
        while (bus.out_valid !== 1'b1 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        held = bus.out_sample;
        tests += 2;
        if (c !== 17) begin
            fails++; $display("FAIL bp_phase2_latency got=%0d exp=17", c);
        end
        if (held !== 24'h100000) begin
            fails++; $display("FAIL bp_phase2_value got=%h exp=100000", held);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests += 3;
            if (bus.out_valid !== 1'b1) begin
                fails++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, bus.out_valid);
            end
            if (bus.out_sample !== held) begin
                fails++;
                $display("FAIL bp_hold_sample cyc=%0d got=%h exp=%h", i, bus.out_sample, held);
            end
            if (bus.in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        get_out(v, c);
        tests += 2;
        if (c !== 17) begin
            fails++; $display("FAIL bp_phase3_latency got=%0d exp=17", c);
        end
        if (v !== 24'h100000) begin
            fails++; $display("FAIL bp_phase3_value got=%h exp=100000", v);
        end
    endtask

    task automatic test_rejected_write();
        logic [23:0] v;
        logic [23:0] exp_b [4];
        int          c;
        do_reset();
        for (int p = 0; p < 4; p++) write_coef(p * 16, 16'h4000);
        send(24'h100000);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 6'd16;
        bus.coef_wdata = 16'h2000;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        tests++;
        if (bus.coef_err !== 1'b1) begin
            fails++; $display("FAIL rej_err_pulse got=%b exp=1", bus.coef_err);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.coef_err !== 1'b0) begin
            fails++; $display("FAIL rej_err_width got=%b exp=0", bus.coef_err);
        end
        for (int p = 0; p < 4; p++) begin
            get_out(v, c);
            tests++;
            if (v !== 24'h080000) begin
                fails++; $display("FAIL rej_unchanged phase=%0d got=%h exp=080000", p, v);
            end
        end
        write_coef(16, 16'h2000);
        tests++;
        if (bus.coef_err !== 1'b0) begin
            fails++; $display("FAIL idle_write_err got=%b exp=0", bus.coef_err);
        end
        // Coefficient write coinciding with the input handshake.
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 6'd32;
        bus.coef_wdata = 16'h2000;
        send(24'h100000);
        bus.coef_we = 1'b0;
        exp_b[0] = 24'h080000;
        exp_b[1] = 24'h040000;
        exp_b[2] = 24'h040000;
        exp_b[3] = 24'h080000;
        for (int p = 0; p < 4; p++) begin
            get_out(v, c);
            tests++;
            if (v !== exp_b[p]) begin
                fails++; $display("FAIL idle_write_effect phase=%0d got=%h exp=%h", p, v, exp_b[p]);
            end
        end
        tests++;
        if (bus.coef_err !== 1'b0) begin
            fails++; $display("FAIL handshake_write_err got=%b exp=0", bus.coef_err);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [23:0] v;
        int          c;
        do_reset();
        for (int p = 0; p < 4; p++) write_coef(p * 16, 16'h4000);
        send(24'h100000);
        get_out(v, c);
        tests++;
        if (v !== 24'h080000) begin
            fails++; $display("FAIL rst_pre_value got=%h exp=080000", v);
        end
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy);
        end
        if (bus.out_sample !== 24'h000000) begin
            fails++; $display("FAIL rst_mid_out_sample got=%h exp=000000", bus.out_sample);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready);
        end
        send(24'h100000);
        for (int p = 0; p < 4; p++) begin
            get_out(v, c);
            tests++;
            if (v !== 24'h000000) begin
                fails++; $display("FAIL rst_zero_coef phase=%0d got=%h exp=000000", p, v);
            end
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus.out_ready  = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        test_reset();
        test_unity();
        test_impulse();
        test_saturation();
        test_backpressure();
        test_rejected_write();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
